// File: rtl/async_pkg.sv
// Shared definitions for the clocked asynchronous-emulation library:
// stage limits, occupancy width helper and handshake-violation codes.
package async_pkg;

    localparam int MAX_DEPTH = 64;

    // Bit positions of the individual violation detectors in muller_pipeline
    typedef enum logic [2:0] {
        REQ_EARLY_FALL,
        REQ_EARLY_RISE,
        DATA_UNSTABLE,
        ACK_EARLY_RISE,
        ACK_EARLY_FALL
    } hs_err_t;

    localparam int NUM_HS_ERR = 5;

    function automatic int occ_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/c_elem_sync.sv
// Clocked N-input Muller C-element: output goes to 1 when all inputs are 1,
// to 0 when all inputs are 0, and holds otherwise.
module c_elem_sync #(
    parameter int size = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [size-1:0] data_in,
    output logic            data_out
);

    logic out_q, out_d;

    always_comb begin
        out_d = out_q;
        if (&data_in)
            out_d = 1'b1;
        else if (~|data_in)
            out_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst)
            out_q <= 1'b0;
        else
            out_q <= out_d;
    end

    assign data_out = out_q;

endmodule

// File: rtl/muller_pipeline.sv
// Four-phase micropipeline emulated under one clock: a chain of C-elements,
// each gating a data register, with occupancy count and sticky protocol check.
module muller_pipeline
    import async_pkg::*;
#(
    parameter int width = 8,
    parameter int depth = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_req,
    output logic                      in_ack,
    input  logic [width-1:0]          in_data,
    output logic                      out_req,
    input  logic                      out_ack,
    output logic [width-1:0]          out_data,
    output logic [occ_w(depth)-1:0]   occupancy,
    output logic                      proto_err
);

    localparam int OW = occ_w(depth);

    if (depth < 2 || depth > MAX_DEPTH) begin : g_bad_depth
        $error("muller_pipeline: depth out of range");
    end

    logic [depth-1:0]            c_w;
    logic [depth-1:0]            a_w;
    logic [depth-1:0]            b_w;
    logic [depth-1:0]            fire_w;
    logic [depth-1:0][width-1:0] d_w;

    for (genvar i = 0; i < depth; i++) begin : g_stage
        logic [width-1:0] d_q, d_d, src_w;

        if (i == 0) begin : g_first
            assign a_w[i]  = in_req;
            assign src_w   = in_data;
        end else begin : g_mid
            assign a_w[i]  = c_w[i-1];
            assign src_w   = d_w[i-1];
        end

        if (i == depth - 1) begin : g_last
            assign b_w[i] = ~out_ack;
        end else begin : g_inner
            assign b_w[i] = ~c_w[i+1];
        end

        c_elem_sync #(.size(2)) u_c (
            .clk      (clk),
            .rst      (rst),
            .data_in  ({a_w[i], b_w[i]}),
            .data_out (c_w[i])
        );

        // Capture only on the edge where this stage's C-element rises
        assign fire_w[i] = a_w[i] & b_w[i] & ~c_w[i];
        assign d_d       = fire_w[i] ? src_w : d_q;

        always_ff @(posedge clk) begin
            if (rst)
                d_q <= '0;
            else
                d_q <= d_d;
        end

        assign d_w[i] = d_q;
    end

    assign in_ack   = c_w[0];
    assign out_req  = c_w[depth-1];
    assign out_data = d_w[depth-1];

    // A stage holds an item when it is set and its successor is not (b_w = ~successor)
    always_comb begin
        occupancy = '0;
        for (int i = 0; i < depth; i++) begin
            if (c_w[i] & b_w[i])
                occupancy = occupancy + OW'(1);
        end
    end

    logic                  in_req_q, in_req_d;
    logic                  out_ack_q, out_ack_d;
    logic [width-1:0]      in_data_q, in_data_d;
    logic                  err_q, err_d;
    logic [NUM_HS_ERR-1:0] viol_w;

    always_comb begin
        viol_w                 = '0;
        viol_w[REQ_EARLY_FALL] = ~in_req & in_req_q & ~in_ack;
        viol_w[REQ_EARLY_RISE] = in_req & ~in_req_q & in_ack;
        viol_w[DATA_UNSTABLE]  = in_req & in_req_q & ~in_ack & (in_data != in_data_q);
        viol_w[ACK_EARLY_RISE] = out_ack & ~out_ack_q & ~out_req;
        viol_w[ACK_EARLY_FALL] = ~out_ack & out_ack_q & out_req;
        err_d                  = err_q | (|viol_w);
        in_req_d               = in_req;
        out_ack_d              = out_ack;
        in_data_d              = in_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_req_q  <= 1'b0;
            out_ack_q <= 1'b0;
            in_data_q <= '0;
            err_q     <= 1'b0;
        end else begin
            in_req_q  <= in_req_d;
            out_ack_q <= out_ack_d;
            in_data_q <= in_data_d;
            err_q     <= err_d;
        end
    end

    assign proto_err = err_q;

endmodule

// File: tb/tb_muller_pipeline.sv
// Directed bench for muller_pipeline (depth 4): latency, stall, streaming,
// protocol violations and mid-operation reset.
module tb_muller_pipeline;
    import async_pkg::*;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int OW = occ_w(D);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_req = 1'b0;
    logic          in_ack;
    logic [W-1:0]  in_data = '0;
    logic          out_req;
    logic          out_ack;
    logic [W-1:0]  out_data;
    logic [OW-1:0] occupancy;
    logic          proto_err;

    logic          cons_en  = 1'b0;
    logic          cons_ack = 1'b0;
    logic          man_ack  = 1'b0;
    logic [W-1:0]  rx[$];

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [W-1:0] din;
        logic [W-1:0] dout;
    } vec_t;
    vec_t vec[8];

    always #5 clk = ~clk;

    assign out_ack = cons_en ? cons_ack : man_ack;

    muller_pipeline #(.width(W), .depth(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_req    (in_req),
        .in_ack    (in_ack),
        .in_data   (in_data),
        .out_req   (out_req),
        .out_ack   (out_ack),
        .out_data  (out_data),
        .occupancy (occupancy),
        .proto_err (proto_err)
    );

    // Four-phase consumer: ack each new request, release once request drops
    always @(negedge clk) begin
        if (!cons_en)
            cons_ack = 1'b0;
        else if (!cons_ack && out_req) begin
            rx.push_back(out_data);
            cons_ack = 1'b1;
        end else if (cons_ack && !out_req)
            cons_ack = 1'b0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tmo(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out", name);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        rst     = 1'b1;
        in_req  = 1'b0;
        man_ack = 1'b0;
        cons_en = 1'b0;
        tick(n);
        rst = 1'b0;
        rx.delete();
    endtask

    task automatic raise(input logic [W-1:0] d);
        int t = 0;
        while (in_ack && t < 50) begin tick(1); t++; end
        if (in_ack) tmo("raise_wait_ack_low");
        in_data = d;
        in_req  = 1'b1;
    endtask

    task automatic wait_ack_drop();
        int t = 0;
        while (!in_ack && t < 50) begin tick(1); t++; end
        if (!in_ack) tmo("wait_ack_high");
        in_req = 1'b0;
    endtask

    task automatic push(input logic [W-1:0] d);
        raise(d);
        wait_ack_drop();
    endtask

    task automatic wait_rx(input int n, input int budget);
        int t = 0;
        while (rx.size() < n && t < budget) begin tick(1); t++; end
        if (rx.size() < n) tmo("wait_rx");
    endtask

    initial begin
        vec[0] = '{8'h01, 8'h01}; vec[1] = '{8'h02, 8'h02};
        vec[2] = '{8'h03, 8'h03}; vec[3] = '{8'h04, 8'h04};
        vec[4] = '{8'h05, 8'h05}; vec[5] = '{8'h06, 8'h06};
        vec[6] = '{8'h07, 8'h07}; vec[7] = '{8'h08, 8'h08};

        // Reset state
        do_reset(2);
        chk("rst_in_ack", in_ack, 0);
        chk("rst_out_req", out_req, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_occ", occupancy, 0);
        chk("rst_err", proto_err, 0);

        // Latency: ack after edge k, delivery after edge k+3
        in_data = 8'hA5;
        in_req  = 1'b1;
        tick(1);
        chk("lat_in_ack", in_ack, 1);
        in_req = 1'b0;
        chk("lat_out_req_k", out_req, 0);
        tick(1); chk("lat_out_req_k1", out_req, 0);
        tick(1); chk("lat_out_req_k2", out_req, 0);
        tick(1);
        chk("lat_out_req_k3", out_req, 1);
        chk("lat_out_data", out_data, 8'hA5);
        chk("lat_occ", occupancy, 1);

        // Stall: capacity two, third request left hanging
        do_reset(1);
        push(8'h11);
        push(8'h22);
        raise(8'h33);
        tick(6);
        chk("stall_in_ack", in_ack, 0);
        chk("stall_occ", occupancy, 2);
        chk("stall_out_req", out_req, 1);
        chk("stall_out_data", out_data, 8'h11);
        cons_en = 1'b1;
        wait_ack_drop();
        wait_rx(3, 100);
        if (rx.size() >= 3) begin
            chk("stall_rx0", rx[0], 8'h11);
            chk("stall_rx1", rx[1], 8'h22);
            chk("stall_rx2", rx[2], 8'h33);
        end
        chk("stall_err", proto_err, 0);

        // Stream of eight items through a live consumer
        do_reset(1);
        cons_en = 1'b1;
        for (int i = 0; i < 8; i++) push(vec[i].din);
        wait_rx(8, 200);
        for (int i = 0; i < 8; i++)
            if (i < rx.size()) chk($sformatf("stream_rx%0d", i), rx[i], vec[i].dout);
        tick(10);
        chk("stream_occ", occupancy, 0);
        chk("stream_err", proto_err, 0);
        chk("stream_out_req", out_req, 0);
        chk("stream_in_ack", in_ack, 0);
        chk("stream_count", rx.size(), 8);

        // Each violation kind raises the sticky flag
        for (int k = 0; k < NUM_HS_ERR; k++) begin
            hs_err_t e;
            e = hs_err_t'(k);
            do_reset(1);
            case (e)
                REQ_EARLY_FALL, DATA_UNSTABLE: begin
                    push(8'h11);
                    push(8'h22);
                    raise(8'h33);
                    tick(4);
                    chk({"pre_", e.name()}, proto_err, 0);
                    if (e == REQ_EARLY_FALL) in_req = 1'b0;
                    else in_data = 8'h44;
                    tick(1);
                end
                REQ_EARLY_RISE: begin
                    in_data = 8'h11;
                    in_req  = 1'b1;
                    tick(1);
                    in_req = 1'b0;
                    tick(1);
                    chk({"pre_", e.name()}, proto_err, 0);
                    in_req = 1'b1;
                    tick(1);
                end
                ACK_EARLY_RISE: begin
                    chk({"pre_", e.name()}, proto_err, 0);
                    man_ack = 1'b1;
                    tick(1);
                end
                default: begin
                    int t = 0;
                    push(8'h11);
                    while (!out_req && t < 20) begin tick(1); t++; end
                    if (!out_req) tmo("viol_wait_out_req");
                    chk({"pre_", e.name()}, proto_err, 0);
                    man_ack = 1'b1;
                    tick(1);
                    man_ack = 1'b0;
                    tick(1);
                end
            endcase
            chk({"viol_", e.name()}, proto_err, 1);
            in_req  = 1'b0;
            man_ack = 1'b0;
            tick(3);
            chk({"sticky_", e.name()}, proto_err, 1);
        end
        do_reset(1);
        chk("err_cleared", proto_err, 0);

        // Reset mid-operation discards held items
        push(8'h11);
        push(8'h22);
        tick(4);
        chk("mid_occ_before", occupancy, 2);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("mid_in_ack", in_ack, 0);
        chk("mid_out_req", out_req, 0);
        chk("mid_out_data", out_data, 0);
        chk("mid_occ", occupancy, 0);
        chk("mid_err", proto_err, 0);
        cons_en = 1'b1;
        push(8'h5A);
        wait_rx(1, 20);
        if (rx.size() >= 1) chk("mid_rx", rx[0], 8'h5A);
        tick(8);
        chk("mid_count", rx.size(), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
